uart_prog_loader: RTL and testbench
===================================

Name: uart_prog_loader

Overview:
On-chip receiver that consumes the boot-time UART program stream driven into the user project and writes it into instruction memory. It deserialises 8N1 bytes, packs four bytes MSB-first into 32-bit words, and issues one word write per word at incrementing word addresses. The word 0x00000FFF is the end-of-program sentinel; it is not written and raises prog_done_o. The block sits between the rx pad and the instruction-memory write port, ahead of core release from reset.

Parameters:
CLKS_PER_BIT, 86, clocks per UART bit (8600 ns bit at 100 ns clock)
MEM_DEPTH, 16384, instruction memory depth in 32-bit words
AW, $clog2(MEM_DEPTH), word-address width (derived, not overridable)
SENTINEL, 32'h0000_0FFF, end-of-program word

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous, active-high reset
rx_i  input  1  UART serial line, idle high, asynchronous to clk_i
en_i  input  1  loader enable (project ready); start bits ignored while low
mem_req_o  output  1  word write request
mem_gnt_i  input  1  memory accepts write this cycle when high with mem_req_o
mem_addr_o  output  AW  word address
mem_wdata_o  output  32  write data
prog_done_o  output  1  sticky: sentinel received
frame_err_o  output  1  sticky: stop bit sampled low
ovf_err_o  output  1  sticky: word dropped (write pending, or memory full)
word_cnt_o  output  AW+1  words written so far

Behaviour:
- Reset is asynchronous, active-high. All outputs reset to 0, rx synchroniser flops to 1, FSM to IDLE, byte index to 0.
- rx_i passes through a 2-flop synchroniser. All timing below is on the synchronised signal.
- Rx FSM states:
  - IDLE: on falling edge with en_i=1, go to START and clear the counter.
  - START: at CLKS_PER_BIT/2 (=43), sample. Low -> DATA. High -> false start, back to IDLE.
  - DATA: sample every CLKS_PER_BIT after the start sample, LSB first, 8 bits, then go to STOP.
  - STOP: sample after CLKS_PER_BIT. High -> byte_valid for 1 cycle, then IDLE. Low -> set frame_err_o, discard the byte and the partial word, reset byte index to 0, go to WAIT_HIGH.
  - WAIT_HIGH: stay until the line is high, then IDLE.
- A start bit stretched by up to CLKS_PER_BIT/2-1 clocks must still decode correctly, since sampling is anchored to the start-bit midpoint.
- Packing: byte index 0..3 fills [31:24], [23:16], [15:8], [7:0]. On the 4th byte_valid the word is complete.
- Word handling, in the cycle after the word completes:
  - Word == SENTINEL: set prog_done_o, no write.
  - Otherwise, if no request is pending and word_cnt_o < MEM_DEPTH: assert mem_req_o with mem_addr_o = word_cnt_o[AW-1:0] and mem_wdata_o = word.
  - Otherwise: drop the word and set ovf_err_o.
- Write handshake:
  - mem_req_o, mem_addr_o and mem_wdata_o stay stable until the cycle mem_gnt_i=1.
  - On that edge mem_req_o drops and word_cnt_o increments.
  - mem_gnt_i is ignored while mem_req_o=0.
- Full memory: word_cnt_o saturates at MEM_DEPTH. mem_addr_o never wraps.
- After prog_done_o: new start bits are ignored and the FSM stays in IDLE. A pending write still completes.
- en_i deasserting mid-byte does not abort the byte. It only gates new start detection.
- Reset mid-byte or mid-request drops everything immediately. No write is issued after reset.

Decomposition:
- Package prog_loader_pkg:
  - rx FSM state enum (IDLE, START, DATA, STOP, WAIT_HIGH)
  - SENTINEL default
  - bit-counter width function of CLKS_PER_BIT
- Sub-module uart_rx_core:
  - Contains the synchroniser, rx FSM, and bit and clock counters.
  - Outputs byte_o[7:0], byte_valid_o and frame_err_o.
- uart_prog_loader contains packing, sentinel detection, the write handshake and the counters.

Test Plan:
- Bytes 0x12,0x34,0x56,0x78 then 0x00,0x00,0x0F,0xFF, with mem_gnt_i tied 1 -> one write: addr 0, data 0x12345678. Then prog_done_o=1, word_cnt_o=1, no second write.
- 255 words from a program.hex image, then the sentinel, with start bits stretched by 10 clocks -> 255 writes at addr 0..254 matching the image. Then prog_done_o=1, frame_err_o=0.
- mem_gnt_i held 0 for 2000 cycles on word 0 -> req, addr and data stay stable. Word 1 completes meanwhile -> ovf_err_o=1 and word 1 dropped. Grant on word 0 -> word_cnt_o=1.
- Stop bit driven low on byte 2 of a word -> frame_err_o=1, partial word discarded. Next four good bytes 0xAABBCCDD -> written at addr 0.
- en_i=0 while a byte is sent, then en_i=1 and a 3-clock low glitch on rx_i -> no byte decoded, no write, FSM back in IDLE.
- rst_i pulsed during DATA of byte 3 -> all outputs 0 immediately. Subsequent full word 0xDEADBEEF written at addr 0.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared types and helpers for the UART program loader
// Contents: rx FSM state enum, default end-of-program word, counter width helper.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    localparam logic [31:0] SENTINEL_DEFAULT = 32'h0000_0FFF;

    // Width of a counter that runs 0 .. clks-1.
    function automatic int cnt_width(input int clks);
        return (clks <= 2) ? 1 : $clog2(clks);
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 UART receiver with start-bit midpoint anchoring
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   rx_i              raw serial line (idle high, asynchronous)
//   start_en_i        new start bits are accepted only while high
//   byte_o            last received byte (LSB first on the line)
//   byte_valid_o      one-cycle pulse when byte_o is fresh
//   frame_err_o       one-cycle pulse when a stop bit is sampled low
module uart_rx_core
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 86
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    input  logic       start_en_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    logic            rx_meta_q;
    logic            rx_sync_q;
    logic            rx_prev_q;
    rx_state_e       state_q;
    logic [CW-1:0]   clk_cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            state_q      <= RX_IDLE;
            clk_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_o       <= '0;
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            rx_meta_q    <= rx_i;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
            unique case (state_q)
                RX_IDLE: begin
                    if (start_en_i && rx_prev_q && !rx_sync_q) begin
                        state_q   <= RX_START;
                        clk_cnt_q <= '0;
                    end
                end
                RX_START: begin
                    // Half-bit sample: all later samples land mid-bit, which
                    // also tolerates a stretched start bit.
                    if (clk_cnt_q == HALF_LAST) begin
                        clk_cnt_q <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
                        shift_q   <= {rx_sync_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
                        if (rx_sync_q) begin
                            byte_o       <= shift_q;
                            byte_valid_o <= 1'b1;
                            state_q      <= RX_IDLE;
                        end else begin
                            frame_err_o <= 1'b1;
                            state_q     <= RX_WAIT_HIGH;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_sync_q) begin
                        state_q <= RX_IDLE;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART boot stream to instruction-memory word writer
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   rx_i, en_i        serial line and loader enable (gates new start bits)
//   mem_req_o/gnt_i   word write handshake; addr/wdata held until granted
//   mem_addr_o        word address (= words written so far, never wraps)
//   mem_wdata_o       write data, bytes packed MSB first
//   prog_done_o       sticky, end-of-program word seen
//   frame_err_o       sticky, a stop bit was low
//   ovf_err_o         sticky, a word was dropped (busy or memory full)
//   word_cnt_o        words written, saturating at MEM_DEPTH
module uart_prog_loader
    import prog_loader_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 86,
    parameter int          MEM_DEPTH    = 16384,
    parameter logic [31:0] SENTINEL     = SENTINEL_DEFAULT,
    localparam int         AW           = $clog2(MEM_DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          rx_i,
    input  logic          en_i,
    output logic          mem_req_o,
    input  logic          mem_gnt_i,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    output logic          prog_done_o,
    output logic          frame_err_o,
    output logic          ovf_err_o,
    output logic [AW:0]   word_cnt_o
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(MEM_DEPTH);

    logic [7:0]    rx_byte;
    logic          rx_byte_valid;
    logic          rx_frame_err;

    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [31:0]   word_q, word_d;
    logic          word_done_q, word_done_d;
    logic          req_q, req_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;
    logic          ovf_q, ovf_d;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_i         (rx_i),
        .start_en_i   (en_i && !done_q),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_byte_valid),
        .frame_err_o  (rx_frame_err)
    );

    always_comb begin
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        word_done_d = 1'b0;
        req_d       = req_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        ferr_d      = ferr_q;
        ovf_d       = ovf_q;

        if (rx_frame_err) begin
            // Partial word is abandoned; the next good byte starts a new word.
            ferr_d     = 1'b1;
            byte_idx_d = '0;
        end else if (rx_byte_valid) begin
            word_d     = {word_q[23:0], rx_byte};
            byte_idx_d = byte_idx_q + 2'd1;
            word_done_d = (byte_idx_q == 2'd3);
        end

        if (req_q && mem_gnt_i) begin
            req_d = 1'b0;
            if (cnt_q < DEPTH_W) begin
                cnt_d = cnt_q + (AW + 1)'(1);
            end
        end

        // Word decision uses the pre-grant request state: a word landing on
        // the grant cycle still counts as colliding with a pending write.
        if (word_done_q) begin
            if (word_q == SENTINEL) begin
                done_d = 1'b1;
            end else if (!req_q && cnt_q < DEPTH_W) begin
                req_d   = 1'b1;
                addr_d  = cnt_q[AW-1:0];
                wdata_d = word_q;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            byte_idx_q  <= '0;
            word_q      <= '0;
            word_done_q <= 1'b0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            word_done_q <= word_done_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            ferr_q      <= ferr_d;
            ovf_q       <= ovf_d;
        end
    end

    assign mem_req_o   = req_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign prog_done_o = done_q;
    assign frame_err_o = ferr_q;
    assign ovf_err_o   = ovf_q;
    assign word_cnt_o  = cnt_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - self-checking bench for uart_prog_loader
module tb_uart_prog_loader;

    localparam int CPB   = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam logic [31:0] SENT = 32'h0000_0FFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx = 1'b1;
    logic          en = 1'b1;
    logic          gnt = 1'b1;
    logic          req;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          done, ferr, ovf;
    logic [AW:0]   cnt;

    int checks = 0;
    int errors = 0;
    int gnt_mode = 0;   // 0: always grant, 1: random grant, 2: never grant

    logic [31:0] cap_data[$];
    int          cap_addr[$];

    // reference model state
    logic [31:0] exp_data[$];
    int          exp_addr[$];
    int          m_cnt;
    bit          m_done;
    bit          m_ovf;

    uart_prog_loader #(
        .CLKS_PER_BIT (CPB),
        .MEM_DEPTH    (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rx_i        (rx),
        .en_i        (en),
        .mem_req_o   (req),
        .mem_gnt_i   (gnt),
        .mem_addr_o  (addr),
        .mem_wdata_o (wdata),
        .prog_done_o (done),
        .frame_err_o (ferr),
        .ovf_err_o   (ovf),
        .word_cnt_o  (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Grant driver, changes well away from the sampling edges.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (gnt_mode)
                0:       gnt = 1'b1;
                1:       gnt = 1'($urandom_range(0, 1));
                default: gnt = 1'b0;
            endcase
        end
    end

    // Capture every accepted write.
    always @(negedge clk) begin
        if (!rst && req && gnt) begin
            cap_addr.push_back(int'(addr));
            cap_data.push_back(wdata);
        end
    end

    // Model: each complete word is either the sentinel, a write to the next
    // free address, or dropped once memory is full.
    function automatic void model_word(input logic [31:0] w);
        if (m_done) return;
        if (w == SENT) begin
            m_done = 1'b1;
        end else if (m_cnt < DEPTH) begin
            exp_addr.push_back(m_cnt);
            exp_data.push_back(w);
            m_cnt++;
        end else begin
            m_ovf = 1'b1;
        end
    endfunction

    task automatic clear_state();
        cap_addr.delete();
        cap_data.delete();
        exp_addr.delete();
        exp_data.delete();
        m_cnt  = 0;
        m_done = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_state();
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int stretch, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB + stretch) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int stretch);
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[i*8 +: 8], stretch, 1'b1);
        end
    endtask

    task automatic compare_writes(input string tag);
        chk({tag, "_nwrites"}, 64'(cap_addr.size()), 64'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 64'(cap_addr[i]), 64'(exp_addr[i]));
            chk($sformatf("%s_data%0d", tag, i), 64'(cap_data[i]), 64'(exp_data[i]));
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == SENT) w = w ^ 32'h1;
        return w;
    endfunction

    initial begin
        logic [31:0] w0, w1;
        int waited;

        // reset state
        #1;
        chk("rst_req", 64'(req), 0);
        chk("rst_addr", 64'(addr), 0);
        chk("rst_wdata", 64'(wdata), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_ferr", 64'(ferr), 0);
        chk("rst_ovf", 64'(ovf), 0);
        chk("rst_cnt", 64'(cnt), 0);
        clear_state();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // basic word then sentinel; later words are ignored
        gnt_mode = 0;
        send_word(32'h1234_5678, 0);
        model_word(32'h1234_5678);
        send_word(SENT, 0);
        model_word(SENT);
        repeat (20) @(negedge clk);
        compare_writes("basic");
        chk("basic_done", 64'(done), 1);
        chk("basic_cnt", 64'(cnt), 1);
        send_word(rand_word(), 0);
        repeat (20) @(negedge clk);
        chk("after_done_nwrites", 64'(cap_addr.size()), 1);
        chk("after_done_cnt", 64'(cnt), 1);

        // random program, maximally stretched start bits, random grant latency
        do_reset();
        gnt_mode = 1;
        for (int i = 0; i < 10; i++) begin
            w0 = rand_word();
            send_word(w0, CPB / 2 - 1);
            model_word(w0);
        end
        send_word(SENT, CPB / 2 - 1);
        model_word(SENT);
        repeat (40) @(negedge clk);
        compare_writes("prog");
        chk("prog_done", 64'(done), 64'(m_done));
        chk("prog_ferr", 64'(ferr), 0);
        chk("prog_ovf", 64'(ovf), 0);
        chk("prog_cnt", 64'(cnt), 64'(m_cnt));

        // stalled grant: request holds, next word overflows
        do_reset();
        gnt_mode = 2;
        w0 = rand_word();
        w1 = rand_word();
        send_word(w0, 0);
        waited = 0;
        while (!req && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("stall_req_seen", 64'(req), 1);
        send_word(w1, 0);
        repeat (1300) @(negedge clk);
        chk("stall_req", 64'(req), 1);
        chk("stall_addr", 64'(addr), 0);
        chk("stall_wdata", 64'(wdata), 64'(w0));
        chk("stall_ovf", 64'(ovf), 1);
        chk("stall_cnt", 64'(cnt), 0);
        gnt_mode = 0;
        repeat (5) @(negedge clk);
        chk("stall_cnt_after", 64'(cnt), 1);
        chk("stall_req_after", 64'(req), 0);
        chk("stall_nwrites", 64'(cap_data.size()), 1);
        if (cap_data.size() > 0) chk("stall_data", 64'(cap_data[0]), 64'(w0));

        // framing error on the third byte discards the partial word
        do_reset();
        send_byte(8'h11, 0, 1'b1);
        send_byte(8'h22, 0, 1'b1);
        send_byte(8'h33, 0, 1'b0);
        repeat (10) @(negedge clk);
        chk("ferr_set", 64'(ferr), 1);
        chk("ferr_no_write", 64'(cap_addr.size()), 0);
        send_word(32'hAABB_CCDD, 0);
        model_word(32'hAABB_CCDD);
        repeat (10) @(negedge clk);
        compare_writes("ferr");
        chk("ferr_cnt", 64'(cnt), 1);

        // disabled byte and a short glitch produce nothing
        do_reset();
        en = 1'b0;
        send_byte(8'h5A, 0, 1'b1);
        en = 1'b1;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_cnt", 64'(cnt), 0);
        chk("glitch_nwrites", 64'(cap_addr.size()), 0);
        chk("glitch_ferr", 64'(ferr), 0);
        w0 = rand_word();
        send_word(w0, 3);
        model_word(w0);
        repeat (10) @(negedge clk);
        compare_writes("glitch");

        // reset in the middle of a byte with a write pending
        do_reset();
        gnt_mode = 2;
        send_word(rand_word(), 0);
        send_byte(8'hA1, 0, 1'b1);
        send_byte(8'hB2, 0, 1'b1);
        send_byte(8'hC3, 0, 1'b1);
        rx = 1'b0;
        repeat (CPB + 3 * CPB) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", 64'(req), 0);
        chk("mid_rst_addr", 64'(addr), 0);
        chk("mid_rst_wdata", 64'(wdata), 0);
        chk("mid_rst_cnt", 64'(cnt), 0);
        chk("mid_rst_flags", 64'({done, ferr, ovf}), 0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_state();
        gnt_mode = 0;
        repeat (30) @(negedge clk);
        send_word(32'hDEAD_BEEF, 0);
        model_word(32'hDEAD_BEEF);
        repeat (10) @(negedge clk);
        compare_writes("post_rst");

        // memory full: extra words dropped, count saturates
        do_reset();
        gnt_mode = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            w0 = rand_word();
            send_word(w0, 0);
            model_word(w0);
        end
        repeat (10) @(negedge clk);
        compare_writes("full");
        chk("full_cnt", 64'(cnt), 64'(m_cnt));
        chk("full_ovf", 64'(ovf), 64'(m_ovf));
        chk("full_req", 64'(req), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
